// File: rtl/riscv_dmem.sv
// rtl/riscv_dmem.sv - data-memory responder for riscv_core: RAM, cycle counter and GPIO MMIO
// Combinational reads; stores commit the core's merged word one cycle after the request.
module riscv_dmem #(
  parameter int          AW        = 10,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        rw,
  input  logic        en,
  input  logic [31:0] ddatout,
  output logic [31:0] rdata,
  output logic [31:0] gpio_out,
  input  logic [31:0] gpio_in,
  output logic        err
);

  typedef enum logic {
    IDLE    = 1'b0,
    WR_PEND = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MAP_NONE = 2'd0,
    MAP_RAM  = 2'd1,
    MAP_MMIO = 2'd2
  } map_t;

  state_t      state_q, state_d;
  map_t        req_map_q, req_map_d;
  map_t        cur_map;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_rw_q, req_rw_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic        err_q, err_d;
  logic        ram_we;

  logic [31:0] mem_q [0:(1<<AW)-1];

  always_comb begin
    cur_map = MAP_NONE;
    if (mem_addr[31:AW+2] == RAM_BASE[31:AW+2]) begin
      cur_map = MAP_RAM;
    end else if (mem_addr[31:4] == MMIO_BASE[31:4]) begin
      cur_map = MAP_MMIO;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (rst) begin
      case (cur_map)
        MAP_RAM: rdata = mem_q[mem_addr[AW+1:2]];
        MAP_MMIO: begin
          case (mem_addr[3:2])
            2'd0:    rdata = cyc_cnt_q;
            2'd1:    rdata = gpio_q;
            2'd2:    rdata = gpio_in;
            default: rdata = 32'h0;
          endcase
        end
        default: rdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    req_map_d  = req_map_q;
    req_addr_d = req_addr_q;
    req_rw_d   = req_rw_q;
    gpio_d     = gpio_q;
    cyc_cnt_d  = cyc_cnt_q + 32'd1;
    err_d      = 1'b0;
    ram_we     = 1'b0;

    // The pending write always uses the old latch, even if a new request lands now.
    if (state_q == WR_PEND) begin
      state_d = IDLE;
      if (req_map_q == MAP_RAM) begin
        ram_we = rst;
      end else if (req_map_q == MAP_MMIO && req_addr_q[3:2] == 2'd1) begin
        gpio_d = ddatout;
      end
    end

    if (en) begin
      req_addr_d = mem_addr;
      req_rw_d   = rw;
      req_map_d  = cur_map;
      err_d      = (cur_map == MAP_NONE);
      if (rw && cur_map != MAP_NONE) begin
        state_d = WR_PEND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_map_q  <= MAP_NONE;
      req_addr_q <= 32'h0;
      req_rw_q   <= 1'b0;
      gpio_q     <= 32'h0;
      cyc_cnt_q  <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_map_q  <= req_map_d;
      req_addr_q <= req_addr_d;
      req_rw_q   <= req_rw_d;
      gpio_q     <= gpio_d;
      cyc_cnt_q  <= cyc_cnt_d;
      err_q      <= err_d;
    end
  end

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[req_addr_q[AW+1:2]] <= ddatout;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], req_addr_q[31:AW+2], req_addr_q[1:0], req_rw_q};

  assign gpio_out = gpio_q;
  assign err      = err_q;

endmodule

// File: tb/tb_riscv_dmem.sv
// tb/tb_riscv_dmem.sv - table-driven bench for riscv_dmem
// One vector per clock: inputs driven at negedge, outputs checked 1ns later.
module tb_riscv_dmem;

  localparam logic [31:0] M = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        rw;
  logic        en;
  logic [31:0] ddatout;
  logic [31:0] rdata;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  riscv_dmem #(.AW(10), .RAM_BASE(32'h0000_0000), .MMIO_BASE(M)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .rw(rw), .en(en),
    .ddatout(ddatout), .rdata(rdata), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] dout;
    logic [31:0] gin;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_gpio;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(input logic e, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] g,
                              input logic [31:0] rd, input logic er, input logic [31:0] gp);
    vec_t v;
    v.en = e; v.rw = w; v.addr = a; v.dout = d; v.gin = g;
    v.exp_rd = rd; v.exp_err = er; v.exp_gpio = gp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    vt[0]  = mk(0, 0, M,             32'h0,         32'h0,    32'd0,         0, 32'h0);
    vt[1]  = mk(0, 0, M,             32'h0,         32'h0,    32'd1,         0, 32'h0);
    vt[2]  = mk(0, 0, M,             32'h0,         32'h0,    32'd2,         0, 32'h0);
    vt[3]  = mk(1, 0, 32'h14,        32'h0,         32'h0,    32'hDEADBEEF,  0, 32'h0);
    vt[4]  = mk(1, 0, 32'h15,        32'h0,         32'h0,    32'hDEADBEEF,  0, 32'h0);
    vt[5]  = mk(1, 0, 32'h17,        32'h0,         32'h0,    32'hDEADBEEF,  0, 32'h0);
    vt[6]  = mk(1, 1, 32'h20,        32'h0,         32'h0,    32'h11111111,  0, 32'h0);
    vt[7]  = mk(0, 0, 32'h20,        32'h12345678,  32'h0,    32'h11111111,  0, 32'h0);
    vt[8]  = mk(0, 0, 32'h20,        32'h0,         32'h0,    32'h12345678,  0, 32'h0);
    vt[9]  = mk(1, 1, 32'h20,        32'h0,         32'h0,    32'h12345678,  0, 32'h0);
    vt[10] = mk(1, 0, 32'h20,        32'hCAFEF00D,  32'h0,    32'h12345678,  0, 32'h0);
    vt[11] = mk(0, 0, 32'h20,        32'h0,         32'h0,    32'hCAFEF00D,  0, 32'h0);
    vt[12] = mk(1, 1, M + 32'h4,     32'h0,         32'h0,    32'h0,         0, 32'h0);
    vt[13] = mk(0, 0, M + 32'h4,     32'hA5A50001,  32'h0,    32'h0,         0, 32'h0);
    vt[14] = mk(0, 0, M + 32'h4,     32'h0,         32'h0,    32'hA5A50001,  0, 32'hA5A50001);
    vt[15] = mk(1, 0, M + 32'h8,     32'h0,         32'h0F0F, 32'h0F0F,      0, 32'hA5A50001);
    vt[16] = mk(1, 1, M,             32'h0,         32'h0F0F, 32'd16,        0, 32'hA5A50001);
    vt[17] = mk(0, 0, M,             32'h0,         32'h0F0F, 32'd17,        0, 32'hA5A50001);
    vt[18] = mk(0, 0, M,             32'h0,         32'h0F0F, 32'd18,        0, 32'hA5A50001);
    vt[19] = mk(1, 0, M + 32'hC,     32'h0,         32'h0F0F, 32'h0,         0, 32'hA5A50001);
    vt[20] = mk(1, 1, 32'h8000_0000, 32'h0,         32'h0F0F, 32'h0,         0, 32'hA5A50001);
    vt[21] = mk(0, 0, 32'h20,        32'hBAD0BAD0,  32'h0F0F, 32'hCAFEF00D,  1, 32'hA5A50001);
    vt[22] = mk(0, 0, 32'h20,        32'h0,         32'h0F0F, 32'hCAFEF00D,  0, 32'hA5A50001);

    dut.mem_q[5] = 32'hDEADBEEF;
    dut.mem_q[8] = 32'h11111111;

    rst = 1'b0; en = 1'b1; rw = 1'b1; mem_addr = 32'h20;
    ddatout = 32'hFFFF_FFFF; gpio_in = 32'h0;

    // Store requests held during reset must not disturb RAM or gpio_out.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_addr = (i == 1) ? M + 32'h4 : 32'h20;
      #1;
      check($sformatf("rst%0d_rdata", i), rdata, 32'h0);
      check($sformatf("rst%0d_gpio", i), gpio_out, 32'h0);
      check($sformatf("rst%0d_err", i), {31'h0, err}, 32'h0);
    end

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      rst = 1'b1;
      en = vt[i].en; rw = vt[i].rw; mem_addr = vt[i].addr;
      ddatout = vt[i].dout; gpio_in = vt[i].gin;
      #1;
      check($sformatf("v%0d_rdata", i), rdata, vt[i].exp_rd);
      check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vt[i].exp_err});
      check($sformatf("v%0d_gpio", i), gpio_out, vt[i].exp_gpio);
    end

    // Reset landing on the WR_PEND edge must drop the pending store.
    @(negedge clk);
    en = 1'b1; rw = 1'b1; mem_addr = 32'h20; ddatout = 32'h55555555;
    @(negedge clk);
    en = 1'b0; rw = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rdata", rdata, 32'hCAFEF00D);
    check("abort_gpio", gpio_out, 32'h0);
    check("abort_err", {31'h0, err}, 32'h0);

    // Counter wrap.
    @(negedge clk);
    mem_addr = M;
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    #1;
    check("wrap_pre", rdata, 32'hFFFF_FFFF);
    release dut.cyc_cnt_q;
    @(negedge clk);
    #1;
    check("wrap_zero", rdata, 32'h0);
    @(negedge clk);
    #1;
    check("wrap_one", rdata, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
